// File: rtl/matrix_frame_loader.sv
// matrix_frame_loader
//   Parses framed byte packets and drives the pixel-memory write port of the
//   matrix LED driver.
//   Packet: A5, ADDR_HI (bit0 = addr[8], bits 7:1 zero), ADDR_LO, LEN,
//           LEN+1 payload bytes, CHK (XOR of the payload).
//   Ports:
//     clk, rst           : clock, synchronous active-high reset
//     rx_data, rx_valid  : one byte per rx_valid pulse (back-to-back allowed)
//     address_out        : pixel address, valid with write_strobe_out
//     data_out           : pixel value, valid with write_strobe_out
//     write_strobe_out   : one-cycle write enable
//     frame_done         : pulse, packet ended with a good checksum
//     frame_error        : pulse, bad header / bad checksum / inter-byte timeout
//   All outputs are registered; results appear one cycle after the byte.
module matrix_frame_loader #(
  parameter int OUTPUTS_TOTAL  = 128,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [8:0] address_out,
  output logic [7:0] data_out,
  output logic       write_strobe_out,
  output logic       frame_done,
  output logic       frame_error
);

  localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [10:0] OUT_LIM = 11'(OUTPUTS_TOTAL);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN, S_DATA, S_CHECK
  } state_t;

  state_t        state, state_n;
  logic [9:0]    addr_cnt, addr_cnt_n;
  logic [7:0]    remaining, remaining_n;
  logic [7:0]    chk_acc, chk_acc_n;
  logic [TW-1:0] idle_cnt, idle_cnt_n;
  logic [8:0]    address_n;
  logic [7:0]    data_n;
  logic          strobe_n, done_n, error_n;

  always_comb begin
    state_n     = state;
    addr_cnt_n  = addr_cnt;
    remaining_n = remaining;
    chk_acc_n   = chk_acc;
    address_n   = address_out;
    data_n      = data_out;
    strobe_n    = 1'b0;
    done_n      = 1'b0;
    error_n     = 1'b0;
    // Counts clocks since the last byte; only meaningful inside a packet.
    idle_cnt_n  = (state == S_IDLE || rx_valid) ? '0 : idle_cnt + TW'(1);

    if (rx_valid) begin
      // A byte landing in the timeout cycle wins over the timeout.
      unique case (state)
        S_IDLE: begin
          if (rx_data == 8'hA5) state_n = S_ADDR_HI;
        end
        S_ADDR_HI: begin
          if (rx_data[7:1] != 7'd0) begin
            error_n = 1'b1;
            state_n = S_IDLE;
          end else begin
            addr_cnt_n = {1'b0, rx_data[0], 8'h00};
            state_n    = S_ADDR_LO;
          end
        end
        S_ADDR_LO: begin
          addr_cnt_n[7:0] = rx_data;
          state_n         = S_LEN;
        end
        S_LEN: begin
          remaining_n = rx_data;
          chk_acc_n   = 8'h00;
          state_n     = S_DATA;
        end
        S_DATA: begin
          chk_acc_n = chk_acc ^ rx_data;
          if ({1'b0, addr_cnt} < OUT_LIM) begin
            strobe_n  = 1'b1;
            address_n = addr_cnt[8:0];
            data_n    = rx_data;
          end
          // Saturate rather than wrap so an overrun never aliases to address 0.
          if (addr_cnt != 10'h3FF) addr_cnt_n = addr_cnt + 10'd1;
          if (remaining == 8'd0) state_n = S_CHECK;
          else                   remaining_n = remaining - 8'd1;
        end
        S_CHECK: begin
          if (rx_data == chk_acc) done_n  = 1'b1;
          else                    error_n = 1'b1;
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end else if (state != S_IDLE && idle_cnt == TO_LIM) begin
      error_n = 1'b1;
      state_n = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      addr_cnt         <= '0;
      remaining        <= '0;
      chk_acc          <= '0;
      idle_cnt         <= '0;
      address_out      <= '0;
      data_out         <= '0;
      write_strobe_out <= 1'b0;
      frame_done       <= 1'b0;
      frame_error      <= 1'b0;
    end else begin
      state            <= state_n;
      addr_cnt         <= addr_cnt_n;
      remaining        <= remaining_n;
      chk_acc          <= chk_acc_n;
      idle_cnt         <= idle_cnt_n;
      address_out      <= address_n;
      data_out         <= data_n;
      write_strobe_out <= strobe_n;
      frame_done       <= done_n;
      frame_error      <= error_n;
    end
  end

endmodule

// File: tb/tb_matrix_frame_loader.sv
// tb_matrix_frame_loader
//   Directed bench for matrix_frame_loader with OUTPUTS_TOTAL=128 and
//   TIMEOUT_CYCLES=20. Each byte is driven for one clock; outputs are sampled
//   1 time unit after the edge that consumed it, i.e. in the cycle where the
//   registered result of that byte is visible.
module tb_matrix_frame_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [8:0] address_out;
  logic [7:0] data_out;
  logic       write_strobe_out;
  logic       frame_done;
  logic       frame_error;

  int checks   = 0;
  int failures = 0;

  matrix_frame_loader #(
    .OUTPUTS_TOTAL (128),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .address_out     (address_out),
    .data_out        (data_out),
    .write_strobe_out(write_strobe_out),
    .frame_done      (frame_done),
    .frame_error     (frame_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Flags only: strobe, done, error.
  task automatic flags(input string tag, input logic s, input logic d, input logic e);
    chk({tag, ".strobe"}, 32'(write_strobe_out), 32'(s));
    chk({tag, ".done"},   32'(frame_done),       32'(d));
    chk({tag, ".error"},  32'(frame_error),      32'(e));
  endtask

  // Byte that must produce a write at addr with data.
  task automatic send_wr(input string tag, input logic [7:0] b, input logic [8:0] a);
    send(b);
    flags(tag, 1'b1, 1'b0, 1'b0);
    chk({tag, ".addr"}, 32'(address_out), 32'(a));
    chk({tag, ".data"}, 32'(data_out),    32'(b));
  endtask

  task automatic send_quiet(input string tag, input logic [7:0] b);
    send(b);
    flags(tag, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_hdr(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                          input logic [7:0] len);
    send_quiet({tag, ".sync"}, 8'hA5);
    send_quiet({tag, ".hi"},   hi);
    send_quiet({tag, ".lo"},   lo);
    send_quiet({tag, ".len"},  len);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick();
    tick();
    chk("rst.addr", 32'(address_out), 32'h0);
    chk("rst.data", 32'(data_out),    32'h0);
    flags("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // Junk before sync is silently dropped.
    send_quiet("junk0", 8'h00);
    send_quiet("junk1", 8'hFF);

    // Basic write: three bytes at 0x010.., checksum 11^22^33 = 00.
    send_hdr("basic", 8'h00, 8'h10, 8'h02);
    send_wr("basic.d0", 8'h11, 9'h010);
    send_wr("basic.d1", 8'h22, 9'h011);
    send_wr("basic.d2", 8'h33, 9'h012);
    send("basic.chk" == "" ? 8'h00 : 8'h00);
    flags("basic.chk", 1'b0, 1'b1, 1'b0);
    tick();
    flags("basic.after", 1'b0, 1'b0, 1'b0);
    chk("basic.hold_addr", 32'(address_out), 32'h012);
    chk("basic.hold_data", 32'(data_out),    32'h33);

    // Max length, one byte per clock, payload i = 0..255 at base 0.
    // Only 0..127 are writable; XOR of 0..255 is 00.
    send_hdr("max", 8'h00, 8'h00, 8'hFF);
    for (int i = 0; i < 256; i++) begin
      if (i < 128) send_wr("max.wr", 8'(i), 9'(i));
      else         send_quiet("max.sup", 8'(i));
    end
    chk("max.hold_addr", 32'(address_out), 32'h07F);
    chk("max.hold_data", 32'(data_out),    32'h7F);
    send(8'h00);
    flags("max.chk", 1'b0, 1'b1, 1'b0);

    // Range edge: 0x7E, 0x7F written, 0x80, 0x81 suppressed; CHK 04.
    send_hdr("range", 8'h00, 8'h7E, 8'h03);
    send_wr("range.d0", 8'h01, 9'h07E);
    send_wr("range.d1", 8'h02, 9'h07F);
    send_quiet("range.d2", 8'h03);
    send_quiet("range.d3", 8'h04);
    send(8'h04);
    flags("range.chk", 1'b0, 1'b1, 1'b0);

    // Address bit 8 set: 0x100 is beyond 128, no write, still completes.
    send_hdr("hi8", 8'h01, 8'h00, 8'h00);
    send_quiet("hi8.d0", 8'h77);
    send(8'h77);
    flags("hi8.chk", 1'b0, 1'b1, 1'b0);

    // Bad ADDR_HI: error right after it, following byte is ignored in IDLE.
    send_quiet("badhdr.sync", 8'hA5);
    send(8'h02);
    flags("badhdr.hi", 1'b0, 1'b0, 1'b1);
    send_quiet("badhdr.next", 8'h11);

    // Bad checksum: writes land, then error (correct CHK is FF).
    send_hdr("badchk", 8'h00, 8'h20, 8'h01);
    send_wr("badchk.d0", 8'h0F, 9'h020);
    send_wr("badchk.d1", 8'hF0, 9'h021);
    send(8'hFE);
    flags("badchk.chk", 1'b0, 1'b0, 1'b1);

    // Timeout: truncated packet. Last byte consumed in cycle t; the counter
    // reads 20 in cycle t+21, so the error is visible in cycle t+22.
    send_hdr("to", 8'h00, 8'h05, 8'h03);
    send_wr("to.d0", 8'hAA, 9'h005);
    for (int k = 0; k < 20; k++) begin
      tick();
      flags("to.wait", 1'b0, 1'b0, 1'b0);
    end
    tick();
    flags("to.fire", 1'b0, 1'b0, 1'b1);
    tick();
    flags("to.after", 1'b0, 1'b0, 1'b0);
    send_hdr("to.recover", 8'h00, 8'h03, 8'h00);
    send_wr("to.recover.d0", 8'hC3, 9'h003);
    send(8'hC3);
    flags("to.recover.chk", 1'b0, 1'b1, 1'b0);

    // Byte arriving exactly in the timeout cycle is consumed, no timeout.
    send_hdr("toedge", 8'h00, 8'h40, 8'h01);
    for (int k = 0; k < 20; k++) tick();
    send_wr("toedge.d0", 8'h12, 9'h040);
    send_wr("toedge.d1", 8'h34, 9'h041);
    send(8'h26);
    flags("toedge.chk", 1'b0, 1'b1, 1'b0);

    // Reset mid-packet, with a data byte presented in the reset cycle.
    send_hdr("rstmid", 8'h00, 8'h08, 8'h03);
    send_wr("rstmid.d0", 8'h55, 9'h008);
    rx_data  = 8'h66;
    rx_valid = 1'b1;
    rst      = 1'b1;
    tick();
    rx_valid = 1'b0;
    rst      = 1'b0;
    flags("rstmid", 1'b0, 1'b0, 1'b0);
    chk("rstmid.addr", 32'(address_out), 32'h0);
    chk("rstmid.data", 32'(data_out),    32'h0);
    send_hdr("rstmid.pkt", 8'h00, 8'h00, 8'h00);
    send_wr("rstmid.pkt.d0", 8'h5A, 9'h000);
    send(8'h5A);
    flags("rstmid.pkt.chk", 1'b0, 1'b1, 1'b0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
